// File: rtl/vga_fill_engine.sv
`timescale 1ns/1ps
// Rectangle-fill and direct-pixel write sequencer for the frame RAM CPU write port.
// Wishbone registers queue fill commands; the engine emits at most one pixel per clock.
module vga_fill_engine #(
    parameter int ROW_W     = 10,
    parameter int COL_W     = 10,
    parameter int RGB_W     = 12,
    parameter int MAX_ROW   = 599,
    parameter int MAX_COL   = 799,
    parameter int CMD_DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [7:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             pix_we,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic [RGB_W-1:0] pix_rgb,
    output logic             busy
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(MAX_ROW);
    localparam logic [COL_W:0]   COL_LIM  = (COL_W + 1)'(MAX_COL);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] h;
        logic [COL_W-1:0] w;
        logic [RGB_W-1:0] rgb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

    state_t           state_q, state_d;
    logic             ack_q, ack_d;
    logic [ROW_W-1:0] org_row_q, org_row_d, size_h_q, size_h_d;
    logic [COL_W-1:0] org_col_q, org_col_d, size_w_q, size_w_d;
    logic [RGB_W-1:0] color_q, color_d;
    logic             ovf_q, ovf_d, clip_q, clip_d, pend_q, pend_d;
    logic [ROW_W-1:0] dir_row_q, dir_row_d;
    logic [COL_W-1:0] dir_col_q, dir_col_d;
    logic [RGB_W-1:0] dir_rgb_q, dir_rgb_d;
    cmd_t             fifo_q [CMD_DEPTH];
    cmd_t             fifo_d [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] r_q, r_d, row_end_q, row_end_d;
    logic [COL_W-1:0] c_q, c_d, col0_q, col0_d, col_end_q, col_end_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             pix_we_q, pix_we_d;
    logic [ROW_W-1:0] pix_row_q, pix_row_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic [RGB_W-1:0] pix_rgb_q, pix_rgb_d;

    logic             wr_en, push, pop, abort, busy_w;
    logic [2:0]       reg_sel;
    cmd_t             head;
    logic [ROW_W:0]   row_sum, dir_row_x;
    logic [COL_W:0]   col_sum, dir_col_x;
    logic [31:0]      rd_data;
    logic             unused_adr;

    // Bus handshake: a transfer is requested while cyc&stb are high and completes in the
    // single cycle wb_ack_o is high; register writes commit on the edge that ends that cycle.
    assign wr_en      = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    assign reg_sel    = wb_adr_i[4:2];
    assign unused_adr = ^{wb_adr_i[7:5], wb_adr_i[1:0]};
    assign pop        = (state_q == LOAD);
    assign head       = fifo_q[rd_ptr_q];
    assign row_sum    = {1'b0, head.row} + {1'b0, head.h} - (ROW_W + 1)'(1);
    assign col_sum    = {1'b0, head.col} + {1'b0, head.w} - (COL_W + 1)'(1);
    assign dir_row_x  = {1'b0, wb_dat_i[22 +: ROW_W]};
    assign dir_col_x  = {1'b0, wb_dat_i[12 +: COL_W]};
    assign busy_w     = (state_q != IDLE) | (cnt_q != '0) | pend_q | pix_we_q;

    always_comb begin
        ack_d     = ~ack_q & wb_stb_i & wb_cyc_i;
        state_d   = state_q;
        org_row_d = org_row_q;
        org_col_d = org_col_q;
        size_h_d  = size_h_q;
        size_w_d  = size_w_q;
        color_d   = color_q;
        ovf_d     = ovf_q;
        clip_d    = clip_q;
        pend_d    = pend_q;
        dir_row_d = dir_row_q;
        dir_col_d = dir_col_q;
        dir_rgb_d = dir_rgb_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        c_d       = c_q;
        col0_d    = col0_q;
        row_end_d = row_end_q;
        col_end_d = col_end_q;
        rgb_d     = rgb_q;
        pix_we_d  = 1'b0;
        pix_row_d = pix_row_q;
        pix_col_d = pix_col_q;
        pix_rgb_d = pix_rgb_q;
        push      = 1'b0;
        abort     = 1'b0;

        // A pending direct pixel owns the write port; the fill stalls in place behind it.
        if (pend_q) begin
            pix_we_d  = 1'b1;
            pix_row_d = dir_row_q;
            pix_col_d = dir_col_q;
            pix_rgb_d = dir_rgb_q;
            pend_d    = 1'b0;
        end

        if (wr_en) begin
            case (reg_sel)
                3'd0: begin
                    org_row_d = wb_dat_i[10 +: ROW_W];
                    org_col_d = wb_dat_i[0 +: COL_W];
                end
                3'd1: begin
                    size_h_d = wb_dat_i[10 +: ROW_W];
                    size_w_d = wb_dat_i[0 +: COL_W];
                end
                3'd2: begin
                    color_d = wb_dat_i[0 +: RGB_W];
                    if (cnt_q == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_d[wr_ptr_q] = '{row: org_row_q, col: org_col_q, h: size_h_q,
                                             w: size_w_q, rgb: wb_dat_i[0 +: RGB_W]};
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        push     = 1'b1;
                    end
                end
                3'd3: begin
                    if (wb_dat_i[1]) ovf_d = 1'b0;
                    if (wb_dat_i[2]) clip_d = 1'b0;
                    abort = wb_dat_i[31];
                end
                3'd4: begin
                    if (dir_row_x > ROW_LIM || dir_col_x > COL_LIM) begin
                        clip_d = 1'b1;
                    end else begin
                        pend_d    = 1'b1;
                        dir_row_d = wb_dat_i[22 +: ROW_W];
                        dir_col_d = wb_dat_i[12 +: COL_W];
                        dir_rgb_d = wb_dat_i[0 +: RGB_W];
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: if (cnt_q != '0) state_d = LOAD;
            LOAD: begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (head.w == '0 || head.h == '0) begin
                    state_d = IDLE;
                end else if ({1'b0, head.row} > ROW_LIM || {1'b0, head.col} > COL_LIM) begin
                    clip_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d   = FILL;
                    r_d       = head.row;
                    c_d       = head.col;
                    col0_d    = head.col;
                    rgb_d     = head.rgb;
                    row_end_d = row_sum[ROW_W-1:0];
                    col_end_d = col_sum[COL_W-1:0];
                    if (row_sum > ROW_LIM) begin
                        row_end_d = ROW_LIM[ROW_W-1:0];
                        clip_d    = 1'b1;
                    end
                    if (col_sum > COL_LIM) begin
                        col_end_d = COL_LIM[COL_W-1:0];
                        clip_d    = 1'b1;
                    end
                end
            end
            FILL: if (!pend_q) begin
                pix_we_d  = 1'b1;
                pix_row_d = r_q;
                pix_col_d = c_q;
                pix_rgb_d = rgb_q;
                if (c_q == col_end_q) begin
                    c_d = col0_q;
                    if (r_q == row_end_q) state_d = IDLE;
                    else r_d = r_q + ROW_W'(1);
                end else begin
                    c_d = c_q + COL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase

        if (abort) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = IDLE;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0: begin
                rd_data[10 +: ROW_W] = org_row_q;
                rd_data[0 +: COL_W]  = org_col_q;
            end
            3'd1: begin
                rd_data[10 +: ROW_W] = size_h_q;
                rd_data[0 +: COL_W]  = size_w_q;
            end
            3'd2: rd_data[0 +: RGB_W] = color_q;
            3'd3: begin
                rd_data[0]          = busy_w;
                rd_data[1]          = ovf_q;
                rd_data[2]          = clip_q;
                rd_data[8 +: CNT_W] = cnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            org_row_q <= '0;
            org_col_q <= '0;
            size_h_q  <= '0;
            size_w_q  <= '0;
            color_q   <= '0;
            ovf_q     <= 1'b0;
            clip_q    <= 1'b0;
            pend_q    <= 1'b0;
            dir_row_q <= '0;
            dir_col_q <= '0;
            dir_rgb_q <= '0;
            fifo_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            col0_q    <= '0;
            row_end_q <= '0;
            col_end_q <= '0;
            rgb_q     <= '0;
            pix_we_q  <= 1'b0;
            pix_row_q <= '0;
            pix_col_q <= '0;
            pix_rgb_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            org_row_q <= org_row_d;
            org_col_q <= org_col_d;
            size_h_q  <= size_h_d;
            size_w_q  <= size_w_d;
            color_q   <= color_d;
            ovf_q     <= ovf_d;
            clip_q    <= clip_d;
            pend_q    <= pend_d;
            dir_row_q <= dir_row_d;
            dir_col_q <= dir_col_d;
            dir_rgb_q <= dir_rgb_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            c_q       <= c_d;
            col0_q    <= col0_d;
            row_end_q <= row_end_d;
            col_end_q <= col_end_d;
            rgb_q     <= rgb_d;
            pix_we_q  <= pix_we_d;
            pix_row_q <= pix_row_d;
            pix_col_q <= pix_col_d;
            pix_rgb_q <= pix_rgb_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rd_data;
    assign pix_we   = pix_we_q;
    assign pix_row  = pix_row_q;
    assign pix_col  = pix_col_q;
    assign pix_rgb  = pix_rgb_q;
    assign busy     = busy_w;

endmodule

// File: tb/tb_vga_fill_engine.sv
`timescale 1ns/1ps
// Directed bench for vga_fill_engine: register table, fill-command table and
// hand-written sequences for overflow/abort, direct-write insertion and reset.
module tb_vga_fill_engine;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [7:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        pix_we;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic [11:0] pix_rgb;
    logic        busy;

    vga_fill_engine dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .pix_we(pix_we), .pix_row(pix_row), .pix_col(pix_col),
        .pix_rgb(pix_rgb), .busy(busy)
    );

    // clock / cycle counter
    always #5 wb_clk_i = ~wb_clk_i;
    int cyc_cnt = 0;
    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    int checks   = 0;
    int failures = 0;
    int last_ack = 0;

    // scoreboard: captured pixels {row,col,rgb} with their cycle stamps
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];

    always @(negedge wb_clk_i) begin
        if (pix_we) begin
            got_q.push_back({pix_row, pix_col, pix_rgb});
            got_cyc.push_back(cyc_cnt);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [2:0] r, input logic [31:0] d,
                           output logic [31:0] q);
        logic got;
        got = 1'b0;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
        wb_adr_i = {3'b000, r, 2'b00}; wb_dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wb_ack_o) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout: no ack for reg %0d, required ack within 4 cycles", r);
        end
        q = wb_dat_o;
        last_ack = cyc_cnt;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, r, d, dummy);
    endtask

    task automatic wb_read_check(input string name, input logic [2:0] r, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, r, 32'h0, q);
        check(name, q, exp);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc_cnt < target) begin
            @(posedge wb_clk_i); #1;
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int idle_cyc);
        logic seen;
        seen = 1'b0;
        idle_cyc = -1;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (!busy) begin
                seen = 1'b1;
                idle_cyc = cyc_cnt;
            end else begin
                @(posedge wb_clk_i); #1;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", max_cyc);
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  r;
        logic [31:0] d;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic [9:0]  h;
        logic [9:0]  w;
        logic [11:0] rgb;
        int          npix;
        logic        clip;
    } fill_vec_t;

    reg_vec_t  rv[10];
    fill_vec_t fv[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_c, ack_dr, idle_c, re, ce, dir_idx, j, nprev;
        logic [31:0] dpix;

        rv[0] = '{1'b0, 3'd0, 32'h0,         32'h0};
        rv[1] = '{1'b0, 3'd1, 32'h0,         32'h0};
        rv[2] = '{1'b0, 3'd2, 32'h0,         32'h0};
        rv[3] = '{1'b0, 3'd3, 32'h0,         32'h0};
        rv[4] = '{1'b0, 3'd4, 32'h0,         32'h0};
        rv[5] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h000F_FFFF};
        rv[6] = '{1'b1, 3'd1, 32'h0012_3456, 32'h0002_3456};
        rv[7] = '{1'b0, 3'd5, 32'h0,         32'h0};
        rv[8] = '{1'b0, 3'd7, 32'h0,         32'h0};
        rv[9] = '{1'b1, 3'd0, 32'h0002_8014, 32'h0002_8014};

        fv[0] = '{10'd10,  10'd20,  10'd2, 10'd3,  12'hF00, 6,  1'b0};
        fv[1] = '{10'd598, 10'd798, 10'd4, 10'd4,  12'h0A5, 4,  1'b1};
        fv[2] = '{10'd700, 10'd0,   10'd4, 10'd4,  12'h123, 0,  1'b1};
        fv[3] = '{10'd0,   10'd0,   10'd1, 10'd0,  12'hFFF, 0,  1'b0};
        fv[4] = '{10'd599, 10'd799, 10'd1, 10'd1,  12'h5A5, 1,  1'b0};
        fv[5] = '{10'd0,   10'd800, 10'd1, 10'd1,  12'h111, 0,  1'b1};
        fv[6] = '{10'd300, 10'd795, 10'd2, 10'd10, 12'h777, 10, 1'b1};
        fv[7] = '{10'd0,   10'd0,   10'd0, 10'd5,  12'h222, 0,  1'b0};

        // reset state
        #1 wb_rst_i = 1'b1;
        #2;
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_pix_we", 32'(pix_we), 32'h0);
        check("rst_pix", {pix_row, pix_col, pix_rgb}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;

        // register table
        for (int i = 0; i < 10; i++) begin
            if (rv[i].w) wb_write(rv[i].r, rv[i].d);
            wb_read_check($sformatf("reg%0d_r%0d", i, rv[i].r), rv[i].r, rv[i].exp);
        end

        // ack never back-to-back while strobe is held
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h0C;
        check("ack_seq0", 32'(wb_ack_o), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge wb_clk_i); #1;
            check($sformatf("ack_seq%0d", i), 32'(wb_ack_o), 32'(i % 2));
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // fill-command table
        for (int v = 0; v < 8; v++) begin
            got_q.delete(); got_cyc.delete(); exp_q.delete();
            if (fv[v].h != 0 && fv[v].w != 0 && fv[v].row <= 599 && fv[v].col <= 799) begin
                re = int'(fv[v].row) + int'(fv[v].h) - 1;
                ce = int'(fv[v].col) + int'(fv[v].w) - 1;
                if (re > 599) re = 599;
                if (ce > 799) ce = 799;
                for (int rr = int'(fv[v].row); rr <= re; rr++)
                    for (int cc = int'(fv[v].col); cc <= ce; cc++)
                        exp_q.push_back({10'(rr), 10'(cc), fv[v].rgb});
            end
            wb_write(3'd0, {12'h0, fv[v].row, fv[v].col});
            wb_write(3'd1, {12'h0, fv[v].h, fv[v].w});
            wb_write(3'd2, {20'h0, fv[v].rgb});
            ack_c = last_ack;
            wait_idle(3000, idle_c);
            check($sformatf("fill%0d_npix", v), 32'(got_q.size()), 32'(fv[v].npix));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                check($sformatf("fill%0d_pix%0d", v, i), got_q[i], exp_q[i]);
                check($sformatf("fill%0d_cyc%0d", v, i), 32'(got_cyc[i]), 32'(ack_c + 4 + i));
            end
            if (fv[v].npix > 0) begin
                check($sformatf("fill%0d_idle", v), 32'(idle_c), 32'(ack_c + 4 + fv[v].npix));
                check($sformatf("fill%0d_hold", v), {pix_row, pix_col, pix_rgb},
                      exp_q[exp_q.size() - 1]);
            end else begin
                check($sformatf("fill%0d_idle", v), 32'(idle_c), 32'(ack_c + 3));
            end
            wb_read_check($sformatf("fill%0d_status", v), 3'd3, {29'h0, fv[v].clip, 2'b00});
            wb_write(3'd3, 32'h4);
            wb_read_check($sformatf("fill%0d_clr", v), 3'd3, 32'h0);
        end

        // overflow then abort during a 100x100 fill
        got_q.delete(); got_cyc.delete();
        wb_write(3'd0, 32'h0);
        wb_write(3'd1, {12'h0, 10'd100, 10'd100});
        wb_write(3'd2, 32'h00F);
        for (int i = 0; i < 5; i++) wb_write(3'd2, 32'h0F0 + 32'(i));
        wb_read_check("ovf_status", 3'd3, 32'h0000_0403);
        wb_write(3'd3, 32'h8000_0000);
        ack_c = last_ack;
        wait_cycle(ack_c + 2);
        check("abort_pix_we", 32'(pix_we), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_last_pix", 32'(got_cyc[got_cyc.size() - 1] <= ack_c + 1), 32'h1);
        for (int i = 0; i < 4; i++)
            check($sformatf("ovf_pix%0d", i), got_q[i], {10'd0, 10'(i), 12'h00F});
        wb_read_check("abort_status", 3'd3, 32'h2);
        wb_write(3'd3, 32'h2);
        wb_read_check("ovf_clr", 3'd3, 32'h0);

        // direct write inserted into a 1x8 fill
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        wb_write(3'd1, {12'h0, 10'd1, 10'd8});
        wb_write(3'd2, 32'h00F);
        ack_c = last_ack;
        dpix = {10'd5, 10'd5, 12'h0F0};
        wb_write(3'd4, dpix);
        ack_dr = last_ack;
        wait_idle(100, idle_c);
        dir_idx = (ack_dr + 2) - (ack_c + 4);
        j = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == dir_idx) exp_q.push_back(dpix);
            else begin
                exp_q.push_back({10'd0, 10'(j), 12'h00F});
                j++;
            end
        end
        check("dir_npix", 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            check($sformatf("dir_pix%0d", i), got_q[i], exp_q[i]);
            check($sformatf("dir_cyc%0d", i), 32'(got_cyc[i]), 32'(ack_c + 4 + i));
        end
        check("dir_idle", 32'(idle_c), 32'(ack_c + 13));
        wb_read_check("dir_readback", 3'd4, 32'h0);
        nprev = got_q.size();
        wb_write(3'd4, {10'd600, 10'd0, 12'hABC});
        wait_cycle(last_ack + 4);
        check("dir_oob_npix", 32'(got_q.size()), 32'(nprev));
        wb_read_check("dir_oob_clip", 3'd3, 32'h4);
        wb_write(3'd3, 32'h4);

        // asynchronous reset in the middle of a fill, with an ack in flight
        wb_write(3'd1, {12'h0, 10'd100, 10'd100});
        wb_write(3'd2, 32'h00F);
        wait_cycle(last_ack + 20);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h0C;
        @(posedge wb_clk_i); #1;
        check("mid_ack", 32'(wb_ack_o), 32'h1);
        check("mid_pix_we", 32'(pix_we), 32'h1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst_mid_pix_we", 32'(pix_we), 32'h0);
        check("rst_mid_ack", 32'(wb_ack_o), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        nprev = got_q.size();
        for (int i = 0; i < 5; i++) wb_read_check($sformatf("post_rst_r%0d", i), 3'(i), 32'h0);
        check("post_rst_nopix", 32'(got_q.size()), 32'(nprev));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
